// File: rtl/uart_bank_pkg.sv
// Shared definitions for the N-channel UART bank: register map, STATUS/CONTROL bit
// positions and the serial state encodings.
package uart_bank_pkg;

    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_CTRL   = 2'd2;

    localparam int unsigned ST_RX_AVAIL    = 0;
    localparam int unsigned ST_TX_NOT_FULL = 1;
    localparam int unsigned ST_OVERRUN     = 2;
    localparam int unsigned ST_FRAME_ERR   = 3;
    localparam int unsigned ST_DCD         = 4;
    localparam int unsigned ST_CTS         = 5;
    localparam int unsigned ST_TX_IDLE     = 6;

    localparam int unsigned CTRL_RX_IRQ_EN = 0;
    localparam int unsigned CTRL_TX_IRQ_EN = 1;
    localparam int unsigned CTRL_FLOW_EN   = 2;

    typedef enum logic [1:0] {TxIdle, TxStart, TxData, TxStop} tx_state_e;
    typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;

endpackage

// File: rtl/uart_bank_chan.sv
// One 8N1 UART channel: input synchronisers, RX and TX shifters, RX/TX FIFOs and the
// per-channel DATA/STATUS/CONTROL registers.
module uart_bank_chan
    import uart_bank_pkg::*;
#(
    parameter int unsigned BAUD_DIV   = 868,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clk_ena,
    input  logic       sel,
    input  logic       wr,
    input  logic [1:0] reg_addr,
    input  logic [7:0] wdata,
    output logic [7:0] rd_val,
    output logic       irq,
    input  logic       rxd,
    input  logic       cts_n,
    input  logic       dcd_n,
    output logic       txd,
    output logic       rts_n
);
    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = $clog2(BAUD_DIV);
    localparam logic [CW-1:0] BIT_END   = CW'(BAUD_DIV - 1);
    localparam logic [CW-1:0] HALF_END  = CW'(BAUD_DIV / 2 - 1);
    localparam logic [PW:0]   FIFO_FULL = (PW + 1)'(FIFO_DEPTH);
    localparam logic [PW:0]   RTS_LEVEL = (PW + 1)'(FIFO_DEPTH - 2);

    logic [1:0] rxd_sync_q, cts_sync_q, dcd_sync_q;
    logic       rx_prev_q;
    logic       rx_line, cts, dcd;

    logic       data_rd, data_wr, stat_rd, ctrl_wr;
    logic [2:0] ctrl_q;
    logic       overrun_q, frame_err_q;
    logic [7:0] status;

    logic [7:0]    rx_mem [FIFO_DEPTH];
    logic [PW:0]   rx_wptr_q, rx_rptr_q, rx_count;
    logic          rx_empty, rx_full, rx_pop, rx_wr_en, overrun_set;
    rx_state_e     rx_state_q;
    logic [CW-1:0] rx_cnt_q;
    logic [2:0]    rx_bit_q;
    logic [7:0]    rx_shift_q;
    logic          rx_bit_end, rx_push;

    logic [7:0]    tx_mem [FIFO_DEPTH];
    logic [PW:0]   tx_wptr_q, tx_rptr_q;
    logic          tx_empty, tx_full, tx_push, tx_pop, tx_go;
    logic [7:0]    tx_head;
    tx_state_e     tx_state_q;
    logic [CW-1:0] tx_cnt_q;
    logic [2:0]    tx_bit_q;
    logic [7:0]    tx_shift_q;
    logic          tx_bit_end, txd_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            rxd_sync_q <= 2'b11;
            cts_sync_q <= 2'b11;
            dcd_sync_q <= 2'b11;
            rx_prev_q  <= 1'b1;
        end else if (clk_ena) begin
            rxd_sync_q <= {rxd_sync_q[0], rxd};
            cts_sync_q <= {cts_sync_q[0], cts_n};
            dcd_sync_q <= {dcd_sync_q[0], dcd_n};
            rx_prev_q  <= rx_line;
        end
    end

    assign rx_line = rxd_sync_q[1];
    assign cts     = ~cts_sync_q[1];
    assign dcd     = ~dcd_sync_q[1];

    assign data_rd = sel && !wr && (reg_addr == REG_DATA);
    assign data_wr = sel &&  wr && (reg_addr == REG_DATA);
    assign stat_rd = sel && !wr && (reg_addr == REG_STATUS);
    assign ctrl_wr = sel &&  wr && (reg_addr == REG_CTRL);

    // RX FIFO: a push into a full FIFO survives only if the CPU pops in the same cycle.
    assign rx_count    = rx_wptr_q - rx_rptr_q;
    assign rx_empty    = (rx_wptr_q == rx_rptr_q);
    assign rx_full     = (rx_count == FIFO_FULL);
    assign rx_pop      = data_rd && !rx_empty;
    assign rx_wr_en    = rx_push && (!rx_full || rx_pop);
    assign overrun_set = rx_push && rx_full && !rx_pop;

    assign tx_empty = (tx_wptr_q == tx_rptr_q);
    assign tx_full  = ((tx_wptr_q - tx_rptr_q) == FIFO_FULL);
    assign tx_push  = data_wr && !tx_full;
    assign tx_head  = tx_mem[tx_rptr_q[PW-1:0]];
    assign tx_go    = !tx_empty && (!ctrl_q[CTRL_FLOW_EN] || cts);
    assign tx_pop   = tx_go && ((tx_state_q == TxIdle) || ((tx_state_q == TxStop) && tx_bit_end));

    always_ff @(posedge clk) begin
        if (clk_ena && rx_wr_en) rx_mem[rx_wptr_q[PW-1:0]] <= rx_shift_q;
        if (clk_ena && tx_push)  tx_mem[tx_wptr_q[PW-1:0]] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rx_wptr_q <= '0;
            rx_rptr_q <= '0;
            tx_wptr_q <= '0;
            tx_rptr_q <= '0;
        end else if (clk_ena) begin
            if (rx_wr_en) rx_wptr_q <= rx_wptr_q + 1'b1;
            if (rx_pop)   rx_rptr_q <= rx_rptr_q + 1'b1;
            if (tx_push)  tx_wptr_q <= tx_wptr_q + 1'b1;
            if (tx_pop)   tx_rptr_q <= tx_rptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            ctrl_q      <= '0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else if (clk_ena) begin
            if (stat_rd) begin
                overrun_q   <= 1'b0;
                frame_err_q <= 1'b0;
            end
            if (overrun_set)           overrun_q   <= 1'b1;
            if (rx_push && !rx_line)   frame_err_q <= 1'b1;
            if (ctrl_wr)               ctrl_q      <= wdata[2:0];
        end
    end

    assign rx_bit_end = (rx_cnt_q == BIT_END);
    assign rx_push    = (rx_state_q == RxStop) && rx_bit_end;

    always_ff @(posedge clk) begin
        if (!rst) begin
            rx_state_q <= RxIdle;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
        end else if (clk_ena) begin
            rx_cnt_q <= rx_cnt_q + 1'b1;
            unique case (rx_state_q)
                RxIdle: begin
                    rx_cnt_q <= '0;
                    if (rx_prev_q && !rx_line) rx_state_q <= RxStart;
                end
                RxStart: begin
                    if (rx_cnt_q == HALF_END) begin
                        rx_cnt_q   <= '0;
                        rx_bit_q   <= '0;
                        rx_state_q <= rx_line ? RxIdle : RxData;
                    end
                end
                RxData: begin
                    if (rx_bit_end) begin
                        rx_cnt_q   <= '0;
                        rx_shift_q <= {rx_line, rx_shift_q[7:1]};
                        rx_bit_q   <= rx_bit_q + 3'd1;
                        if (rx_bit_q == 3'd7) rx_state_q <= RxStop;
                    end
                end
                RxStop: begin
                    if (rx_bit_end) begin
                        rx_cnt_q   <= '0;
                        rx_state_q <= RxIdle;
                    end
                end
                default: rx_state_q <= RxIdle;
            endcase
        end
    end

    assign tx_bit_end = (tx_cnt_q == BIT_END);

    always_ff @(posedge clk) begin
        if (!rst) begin
            tx_state_q <= TxIdle;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            txd_q      <= 1'b1;
        end else if (clk_ena) begin
            tx_cnt_q <= tx_cnt_q + 1'b1;
            unique case (tx_state_q)
                TxIdle: begin
                    tx_cnt_q <= '0;
                    if (tx_go) begin
                        tx_state_q <= TxStart;
                        tx_shift_q <= tx_head;
                        txd_q      <= 1'b0;
                    end
                end
                TxStart: begin
                    if (tx_bit_end) begin
                        tx_cnt_q   <= '0;
                        tx_bit_q   <= '0;
                        tx_state_q <= TxData;
                        txd_q      <= tx_shift_q[0];
                    end
                end
                TxData: begin
                    if (tx_bit_end) begin
                        tx_cnt_q <= '0;
                        if (tx_bit_q == 3'd7) begin
                            tx_state_q <= TxStop;
                            txd_q      <= 1'b1;
                        end else begin
                            tx_bit_q   <= tx_bit_q + 3'd1;
                            tx_shift_q <= {1'b0, tx_shift_q[7:1]};
                            txd_q      <= tx_shift_q[1];
                        end
                    end
                end
                TxStop: begin
                    if (tx_bit_end) begin
                        tx_cnt_q <= '0;
                        if (tx_go) begin
                            tx_state_q <= TxStart;
                            tx_shift_q <= tx_head;
                            txd_q      <= 1'b0;
                        end else begin
                            tx_state_q <= TxIdle;
                        end
                    end
                end
                default: tx_state_q <= TxIdle;
            endcase
        end
    end

    assign txd = txd_q;

    always_comb begin
        status                 = '0;
        status[ST_RX_AVAIL]    = !rx_empty;
        status[ST_TX_NOT_FULL] = !tx_full;
        status[ST_OVERRUN]     = overrun_q;
        status[ST_FRAME_ERR]   = frame_err_q;
        status[ST_DCD]         = dcd;
        status[ST_CTS]         = cts;
        status[ST_TX_IDLE]     = (tx_state_q == TxIdle);
    end

    always_comb begin
        rd_val = '0;
        case (reg_addr)
            REG_DATA:   rd_val = rx_empty ? 8'h00 : rx_mem[rx_rptr_q[PW-1:0]];
            REG_STATUS: rd_val = status;
            REG_CTRL:   rd_val = {5'b0, ctrl_q};
            default:    rd_val = '0;
        endcase
    end

    assign irq   = (ctrl_q[CTRL_RX_IRQ_EN] && !rx_empty) || (ctrl_q[CTRL_TX_IRQ_EN] && tx_empty);
    assign rts_n = ctrl_q[CTRL_FLOW_EN] && (rx_count >= RTS_LEVEL);

endmodule

// File: rtl/uart_bank_n.sv
// NUM_CH-channel UART bank: decodes the channel from the register address, muxes the
// read data and registers the single-cycle acknowledge.
module uart_bank_n
    import uart_bank_pkg::*;
#(
    parameter int unsigned NUM_CH     = 2,
    parameter int unsigned BAUD_DIV   = 868,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clk_ena,
    input  logic                      sel,
    input  logic                      wr,
    input  logic [$clog2(NUM_CH)+1:0] addr,
    input  logic [7:0]                wdata,
    output logic [7:0]                rdata,
    output logic                      ack,
    output logic [NUM_CH-1:0]         irq,
    input  logic [NUM_CH-1:0]         uart_rxd,
    input  logic [NUM_CH-1:0]         uart_cts_n,
    input  logic [NUM_CH-1:0]         uart_dcd_n,
    output logic [NUM_CH-1:0]         uart_txd,
    output logic [NUM_CH-1:0]         uart_rts_n
);
    localparam int unsigned AW  = $clog2(NUM_CH) + 2;
    localparam int unsigned CHW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [CHW-1:0]    ch_idx;
    logic [NUM_CH-1:0] ch_sel;
    logic [7:0]        ch_rd [NUM_CH];
    logic [7:0]        rd_mux;

    if (NUM_CH > 1) begin : g_idx_multi
        assign ch_idx = addr[AW-1:2];
    end else begin : g_idx_single
        assign ch_idx = '0;
    end

    // Addresses beyond the last channel select nothing and read as 0.
    always_comb begin
        ch_sel = '0;
        rd_mux = '0;
        for (int i = 0; i < int'(NUM_CH); i++) begin
            if (ch_idx == CHW'(i)) begin
                ch_sel[i] = sel;
                rd_mux    = ch_rd[i];
            end
        end
    end

    for (genvar i = 0; i < int'(NUM_CH); i++) begin : g_chan
        uart_bank_chan #(
            .BAUD_DIV  (BAUD_DIV),
            .FIFO_DEPTH(FIFO_DEPTH)
        ) u_chan (
            .clk     (clk),
            .rst     (rst),
            .clk_ena (clk_ena),
            .sel     (ch_sel[i]),
            .wr      (wr),
            .reg_addr(addr[1:0]),
            .wdata   (wdata),
            .rd_val  (ch_rd[i]),
            .irq     (irq[i]),
            .rxd     (uart_rxd[i]),
            .cts_n   (uart_cts_n[i]),
            .dcd_n   (uart_dcd_n[i]),
            .txd     (uart_txd[i]),
            .rts_n   (uart_rts_n[i])
        );
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            ack   <= 1'b0;
            rdata <= '0;
        end else if (clk_ena) begin
            ack   <= sel;
            rdata <= (sel && !wr) ? rd_mux : 8'h00;
        end
    end

endmodule
